if_id_hazard_stage: RTL

//  Parametrised IF/ID pipeline register with RAW-hazard stall, valid/ready handshake and flush.

---
 rtl/if_id_hazard_stage.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/if_id_hazard_stage.sv
// IF/ID pipeline register with RAW-hazard stall against NUM_FUT in-flight destinations,
// valid/ready handshake, flush and sticky stall timeout. Optional IF_ID_STATS_EN adds stall_cycles.
module if_id_hazard_stage #(
  parameter int unsigned NUM_FUT   = 2,
  parameter int unsigned REG_W     = 5,
  parameter int unsigned MAX_STALL = 15
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [31:0]                dataout,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [NUM_FUT*REG_W-1:0]   rd_fut,
  input  logic [NUM_FUT-1:0]         rd_fut_valid,
  input  logic                       flush,
  input  logic                       id_ready,
  output logic                       out_valid,
  output logic [31:0]                instr,
  output logic [REG_W-1:0]           rs,
  output logic [REG_W-1:0]           rt,
  output logic [REG_W-1:0]           rd,
  output logic                       hazard,
  output logic                       stall_timeout
`ifdef IF_ID_STATS_EN
  ,
  output logic [15:0]                stall_cycles
`endif
);

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_FULL,
    ST_STALL
  } state_e;

  localparam logic [7:0] MAX_CNT = 8'(MAX_STALL);

  state_e             state_q, state_d;
  logic [31:0]        instr_q, instr_d;
  logic [REG_W-1:0]   rs_q, rs_d;
  logic [REG_W-1:0]   rt_q, rt_d;
  logic [REG_W-1:0]   rd_q, rd_d;
  logic [7:0]         stall_cnt_q, stall_cnt_d;
  logic               stall_timeout_q, stall_timeout_d;

  logic [REG_W-1:0]   rs_in, rt_in, rd_in;
  logic [REG_W-1:0]   fut_k;
  logic               hit;
  logic               transfer;

  assign rs_in = REG_W'(dataout[25:21]);
  assign rt_in = REG_W'(dataout[20:16]);
  assign rd_in = REG_W'(dataout[15:11]);

  // Several matching entries simply OR into a single hazard.
  always_comb begin
    hit   = 1'b0;
    fut_k = '0;
    for (int unsigned k = 0; k < NUM_FUT; k++) begin
      fut_k = rd_fut[k*REG_W +: REG_W];
      if (rd_fut_valid[k] && (fut_k != '0) && ((fut_k == rs_in) || (fut_k == rt_in)))
        hit = 1'b1;
    end
  end

  assign hazard    = in_valid && hit;
  assign out_valid = (state_q == ST_FULL);
  assign in_ready  = !hazard && (!out_valid || id_ready) && !flush;
  assign transfer  = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    rs_d        = rs_q;
    rt_d        = rt_q;
    rd_d        = rd_q;
    stall_cnt_d = stall_cnt_q;

    if (flush) begin
      state_d     = ST_EMPTY;
      instr_d     = '0;
      rs_d        = '0;
      rt_d        = '0;
      rd_d        = '0;
      stall_cnt_d = '0;
    end else if (transfer) begin
      state_d     = ST_FULL;
      instr_d     = dataout;
      rs_d        = rs_in;
      rt_d        = rt_in;
      rd_d        = rd_in;
      stall_cnt_d = '0;
    end else begin
      // Drained or empty slot: a hazarded input turns the cycle into a bubble.
      case (state_q)
        ST_FULL: begin
          if (id_ready)
            state_d = (in_valid && hazard) ? ST_STALL : ST_EMPTY;
        end
        default: state_d = (in_valid && hazard) ? ST_STALL : ST_EMPTY;
      endcase
      if ((state_d == ST_STALL) && (stall_cnt_q != MAX_CNT))
        stall_cnt_d = stall_cnt_q + 8'd1;
    end

    stall_timeout_d = stall_timeout_q || (stall_cnt_d == MAX_CNT);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q         <= ST_EMPTY;
      instr_q         <= '0;
      rs_q            <= '0;
      rt_q            <= '0;
      rd_q            <= '0;
      stall_cnt_q     <= '0;
      stall_timeout_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      instr_q         <= instr_d;
      rs_q            <= rs_d;
      rt_q            <= rt_d;
      rd_q            <= rd_d;
      stall_cnt_q     <= stall_cnt_d;
      stall_timeout_q <= stall_timeout_d;
    end
  end

  assign instr         = instr_q;
  assign rs            = rs_q;
  assign rt            = rt_q;
  assign rd            = rd_q;
  assign stall_timeout = stall_timeout_q;

`ifdef IF_ID_STATS_EN
  logic [15:0] stall_cycles_q, stall_cycles_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (hazard && (stall_cycles_q != 16'hFFFF))
      stall_cycles_d = stall_cycles_q + 16'd1;
  end

  always_ff @(posedge clock) begin
    if (!reset) stall_cycles_q <= '0;
    else        stall_cycles_q <= stall_cycles_d;
  end

  assign stall_cycles = stall_cycles_q;
`endif

endmodule
